// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, constants and decode helpers for the 4x4 keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam logic [3:0] ROW_IDLE  = 4'b1111;
   localparam logic [3:0] KEY_STAR  = 4'hE;
   localparam logic [3:0] KEY_HASH  = 4'hF;

   function automatic logic onehot_low(input logic [3:0] v);
      return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
   endfunction

   function automatic logic [3:0] key_map(input logic [3:0] row_onehot_n,
                                          input logic [3:0] col_onehot_n);
      logic [1:0] r;
      logic [1:0] c;
      logic [3:0] code;
      r = 2'd0;
      c = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!row_onehot_n[i]) r = 2'(i);
         if (!col_onehot_n[i]) c = 2'(i);
      end
      case ({r, c})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = KEY_STAR;
         4'hD:    code = 4'h0;
         4'hE:    code = KEY_HASH;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_row_sync.sv
// ============================================================================
// Module      : keypad_row_sync
// Description : Row input register; two stages when KEYPAD_SYNC_EN is defined, else one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_row_sync
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_row,
   output logic [3:0] o_row_s
);

`ifdef KEYPAD_SYNC_EN
   localparam int c_DEPTH = 2;
`else
   localparam int c_DEPTH = 1;
`endif

   logic [3:0] r_stage [c_DEPTH];

   // Idle value on reset so no phantom key is seen while the pipe fills.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < c_DEPTH; i++) r_stage[i] <= ROW_IDLE;
      end else begin
         r_stage[0] <= i_row;
         for (int i = 1; i < c_DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_row_s = r_stage[c_DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 active-low matrix scanner with press/release debounce;
//               KEYPAD_SYNC_EN adds a second row synchronizer stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CNT = 8
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] number,
   output logic       key_valid
);

   localparam int c_CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(SCAN_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(DEBOUNCE_CNT - 1);

   logic [3:0]         w_row_s;
   state_t             r_state;
   logic [c_CNT_W-1:0] r_dwell;
   logic [c_CNT_W-1:0] r_cnt;
   logic [3:0]         r_row_lat;
   logic [3:0]         r_col;
   logic [3:0]         r_number;
   logic               r_key_valid;

   keypad_row_sync u_row_sync (
      .clk     (clk),
      .reset   (reset),
      .i_row   (row),
      .o_row_s (w_row_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= SCAN;
         r_dwell     <= '0;
         r_cnt       <= '0;
         r_row_lat   <= ROW_IDLE;
         r_col       <= COL_RESET;
         r_number    <= 4'h0;
         r_key_valid <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (!enable) begin
            r_state <= SCAN;
            r_dwell <= '0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               SCAN: begin
                  if (r_dwell == c_DWELL_LAST) begin
                     r_dwell <= '0;
                     if (onehot_low(w_row_s)) begin
                        r_row_lat <= w_row_s;
                        r_cnt     <= '0;
                        r_state   <= DEBOUNCE;
                     end else begin
                        r_col <= {r_col[2:0], r_col[3]};
                     end
                  end else begin
                     r_dwell <= r_dwell + 1'b1;
                  end
               end
               DEBOUNCE: begin
                  // Any glitch drops back to a fresh dwell on this same column.
                  if (w_row_s != r_row_lat) begin
                     r_state <= SCAN;
                     r_dwell <= '0;
                     r_cnt   <= '0;
                  end else if (r_cnt == c_CNT_LAST) begin
                     r_number    <= key_map(r_row_lat, r_col);
                     r_key_valid <= 1'b1;
                     r_cnt       <= '0;
                     r_state     <= HELD;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               HELD: begin
                  if (w_row_s != ROW_IDLE) begin
                     r_cnt <= '0;
                  end else if (r_cnt == c_CNT_LAST) begin
                     r_cnt   <= '0;
                     r_dwell <= '0;
                     r_col   <= {r_col[2:0], r_col[3]};
                     r_state <= SCAN;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: r_state <= SCAN;
            endcase
         end
      end
   end

   assign col       = r_col;
   assign number    = r_number;
   assign key_valid = r_key_valid;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner with a behavioural key matrix.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        enable = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  number;
   logic        key_valid;
   logic [15:0] keys = '0;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .row       (row),
      .col       (col),
      .number    (number),
      .key_valid (key_valid)
   );

   always #5 clk = ~clk;

   // Matrix model: a pressed key shorts its row to its column when that column is driven low.
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++)
         if (!col[c])
            for (int r = 0; r < 4; r++)
               if (keys[r*4+c]) row[r] = 1'b0;
   end

   // Reference key legend, index = row*4 + col.
   logic [3:0] key_code [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};

   int         n_checks = 0;
   int         n_pass   = 0;
   int         pulses   = 0;
   int         mon_err  = 0;
   logic       prev_kv  = 1'b0;
   logic [3:0] prev_num = 4'h0;
   logic [3:0] seen [$];

   // Observes every pulse; flags pulses wider than one cycle or number changing without a pulse.
   always @(negedge clk) begin
      if (!reset) begin
         prev_kv  <= 1'b0;
         prev_num <= number;
      end else begin
         if (key_valid) begin
            pulses <= pulses + 1;
            seen.push_back(number);
            if (prev_kv) mon_err <= mon_err + 1;
         end else if (number != prev_num) begin
            mon_err <= mon_err + 1;
         end
         prev_kv  <= key_valid;
         prev_num <= number;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pulse(input int limit, output logic ok, output int waited);
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < limit) begin
         @(negedge clk);
         waited++;
         if (key_valid) ok = 1'b1;
      end
   endtask

   task automatic wait_col(input string name, input logic [3:0] target);
      int n;
      n = 0;
      while (col !== target && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, col, target);
   endtask

   task automatic press_expect(input string name, input int idx, input logic [3:0] code);
      logic ok;
      int   w;
      keys = 16'(1) << idx;
      wait_pulse(80, ok, w);
      check({name, "_pulse"}, ok, 1);
      check({name, "_code"}, number, code);
      if (w < 40) cycles(40 - w);
      keys = '0;
      cycles(40);
   endtask

   task automatic hold_release(input int idx, input int hold, input int rel);
      keys = 16'(1) << idx;
      cycles(hold);
      keys = '0;
      cycles(rel);
   endtask

   typedef struct {
      int         r;
      int         c;
      logic [3:0] code;
   } vec_t;

   vec_t       vt [16];
   logic [3:0] exp_q [$];

   initial begin
      logic       ok;
      int         w;
      int         p0;
      logic [3:0] c0;
      logic [3:0] seen_cols;
      int         idx;

      vt[0]  = '{0, 0, 4'h1}; vt[1]  = '{0, 1, 4'h2}; vt[2]  = '{0, 2, 4'h3}; vt[3]  = '{0, 3, 4'hA};
      vt[4]  = '{1, 0, 4'h4}; vt[5]  = '{1, 1, 4'h5}; vt[6]  = '{1, 2, 4'h6}; vt[7]  = '{1, 3, 4'hB};
      vt[8]  = '{2, 0, 4'h7}; vt[9]  = '{2, 1, 4'h8}; vt[10] = '{2, 2, 4'h9}; vt[11] = '{2, 3, 4'hC};
      vt[12] = '{3, 0, 4'hE}; vt[13] = '{3, 1, 4'h0}; vt[14] = '{3, 2, 4'hF}; vt[15] = '{3, 3, 4'hD};

      // Reset values, with key '1' already held so first-press latency is exact.
      keys = 16'h0001;
      #1 reset = 1'b0;
      #12;
      check("reset_col", col, 4'b1110);
      check("reset_number", number, 4'h0);
      check("reset_key_valid", key_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (SCAN_DIV + DEBOUNCE_CNT - 1) @(posedge clk);
      #1 check("latency_early", key_valid, 0);
      @(posedge clk);
      #1 check("latency_pulse", key_valid, 1);
      check("latency_code", number, 4'h1);
      cycles(28);
      check("hold1_one_pulse", pulses, 1);
      cycles(40);
      check("hold1_no_repeat", pulses, 1);
      keys = '0;
      cycles(40);

      // Bounce on '5': 3 on / 2 off never reaches the stable count.
      p0 = pulses;
      for (int k = 0; k < 4; k++) begin
         keys = 16'(1) << 5;
         cycles(3);
         keys = '0;
         cycles(2);
      end
      check("bounce_no_pulse", pulses, p0);
      keys = 16'(1) << 5;
      wait_pulse(80, ok, w);
      check("bounce_pulse", ok, 1);
      check("bounce_min_wait", (w >= DEBOUNCE_CNT), 1);
      check("bounce_code", number, 4'h5);
      cycles(40);
      keys = '0;
      cycles(40);

      // Two keys in one column: rejected, scanning keeps rotating.
      p0 = pulses;
      seen_cols = '0;
      keys = (16'(1) << 4) | (16'(1) << 8);
      repeat (40) begin
         @(negedge clk);
         seen_cols = seen_cols | ~col;
      end
      check("dual_no_pulse", pulses, p0);
      check("dual_col_rotates", seen_cols, 4'hF);
      keys = '0;
      cycles(20);
      press_expect("hash_after_dual", 14, 4'hF);

      // Asynchronous reset while '9' is being debounced.
      wait_col("wait_col1", 4'b1101);
      p0 = pulses;
      keys = 16'(1) << 10;
      wait_col("wait_col2", 4'b1011);
      repeat (SCAN_DIV + 2) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midreset_col", col, 4'b1110);
      check("midreset_number", number, 4'h0);
      check("midreset_key_valid", key_valid, 0);
      check("midreset_no_pulse", pulses, p0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wait_pulse(80, ok, w);
      check("after_reset_pulse", ok, 1);
      check("after_reset_code", number, 4'h9);
      cycles(40);
      keys = '0;
      cycles(40);

      // enable low freezes scanning while '0' is held.
      enable = 1'b0;
      cycles(2);
      c0 = col;
      p0 = pulses;
      keys = 16'(1) << 13;
      cycles(40);
      check("disabled_col_frozen", col, c0);
      check("disabled_no_pulse", pulses, p0);
      enable = 1'b1;
      wait_pulse(80, ok, w);
      check("reenable_pulse", ok, 1);
      check("reenable_code", number, 4'h0);
      cycles(40);
      check("reenable_single_pulse", pulses, p0 + 1);
      keys = '0;
      cycles(40);

      // Full key map.
      for (int i = 0; i < 16; i++)
         press_expect($sformatf("map_r%0dc%0d", vt[i].r, vt[i].c), vt[i].r * 4 + vt[i].c, vt[i].code);

      // Ordered sequence 1, 8, 6, 5.
      seen.delete();
      hold_release(0, 40, 40);
      hold_release(9, 40, 40);
      hold_release(6, 40, 40);
      hold_release(5, 40, 40);
      check("seq_count", seen.size(), 4);
      if (seen.size() == 4) begin
         check("seq_0", seen[0], 4'h1);
         check("seq_1", seen[1], 4'h8);
         check("seq_2", seen[2], 4'h6);
         check("seq_3", seen[3], 4'h5);
      end

      // Random presses with short chatter; every press yields exactly its legend code.
      seen.delete();
      exp_q.delete();
      for (int n = 0; n < 12; n++) begin
         idx = $urandom_range(15);
         exp_q.push_back(key_code[idx]);
         repeat ($urandom_range(0, 3)) begin
            keys = 16'(1) << idx;
            cycles(1);
            keys = '0;
            cycles(1);
         end
         hold_release(idx, $urandom_range(40, 60), $urandom_range(40, 60));
      end
      cycles(2);
      check("rand_count", seen.size(), exp_q.size());
      for (int n = 0; n < exp_q.size() && n < seen.size(); n++)
         check($sformatf("rand_%0d", n), seen[n], exp_q[n]);

      check("pulse_width_and_number_stability", mon_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
